// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizes and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF     = 4;
  localparam int DW_DEF       = 32;
  localparam int MAXBURST_DEF = 16;

  function automatic int gnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int GW   = gnt_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic            any,
  output logic [GW-1:0]   idx
);

  logic          found;
  logic [GW-1:0] cand;

  // Walk the ring starting just after the previous winner; first hit wins.
  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ burst producers.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic [DW-1:0]            fifo_din,
  output logic                     fifo_wen,
  input  logic                     fifo_full,
  output logic [gnt_w(NREQ)-1:0]   grant_id,
  output logic                     busy
);

  localparam int GW = gnt_w(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  arb_state_e    state;
  logic [GW-1:0] last_gnt;
  logic [CW-1:0] beat_cnt;
  logic          pick_any;
  logic [GW-1:0] pick_idx;
  logic          burst_end;
  logic [DW-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DW +: DW];
  end

  rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req  (req_valid),
    .last (last_gnt),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Gating with rst_n keeps the reset cycle free of writes even mid-burst.
  always_comb begin
    req_ready = '0;
    if (rst_n && busy && !fifo_full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign fifo_wen  = req_valid[grant_id] && req_ready[grant_id];
  assign fifo_din  = data_arr[grant_id];
  assign burst_end = req_last[grant_id] || (beat_cnt == CW'(MAXBURST - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      grant_id <= '0;
      last_gnt <= GW'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= BURST;
            busy     <= 1'b1;
            grant_id <= pick_idx;
            last_gnt <= pick_idx;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (fifo_wen) begin
            if (burst_end) begin
              state    <= IDLE;
              busy     <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomised bench for fifo_wr_arb against a queue-based grant/burst reference model.
module tb_fifo_wr_arb;

  localparam int NREQ     = 4;
  localparam int DW       = 32;
  localparam int MAXBURST = 16;
  localparam int GW       = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic [DW-1:0]       fifo_din;
  logic                fifo_wen;
  logic                fifo_full;
  logic [GW-1:0]       grant_id;
  logic                busy;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .NREQ     (NREQ),
    .DW       (DW),
    .MAXBURST (MAXBURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_din  (fifo_din),
    .fifo_wen  (fifo_wen),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  bit en [NREQ];
  int seq [NREQ];
  int pos [NREQ];
  int blen [NREQ];
  int rem [NREQ];
  bit acc [NREQ];
  bit rand_len;
  int vprob;
  int fullprob;
  bit force_full;

  int m_owner, m_gid, m_last, m_cnt;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int grants [$];
  int beats [$];
  int wen_cyc [$];
  bit prev_busy;

  function automatic logic [DW-1:0] mkData(input int p, input int s);
    return {p[7:0], s[23:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && (rem[i] != 0) && ($urandom_range(99) < vprob);
      req_last[i]  = (pos[i] == blen[i] - 1);
      req_data[i*DW +: DW] = mkData(i, seq[i]);
    end
    fifo_full = force_full || ($urandom_range(99) < fullprob);
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_gid   = 0;
    m_last  = NREQ - 1;
    m_cnt   = 0;
  endtask

  // Mid-cycle: compare against the model, log observations, advance the model.
  task automatic sampleCycle();
    logic [NREQ-1:0] exp_ready;
    bit exp_wen;
    int best, bestd, d;
    @(negedge clk);
    exp_ready = '0;
    exp_wen   = 1'b0;
    if (rst_n && m_owner >= 0 && !fifo_full) begin
      exp_ready[m_owner] = 1'b1;
      exp_wen = req_valid[m_owner];
    end
    checkOutput("busy", busy, m_owner >= 0);
    checkOutput("grant_id", grant_id, m_gid);
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("fifo_wen", fifo_wen, exp_wen);
    if (exp_wen) begin
      checkOutput("fifo_din", fifo_din, req_data[m_owner*DW +: DW]);
      exp_q.push_back(req_data[m_owner*DW +: DW]);
    end
    if (busy && !prev_busy) begin
      grants.push_back(int'(grant_id));
      beats.push_back(0);
    end
    prev_busy = busy;
    if (fifo_wen) begin
      got_q.push_back(fifo_din);
      wen_cyc.push_back(cyc);
      if (beats.size() > 0) beats[beats.size()-1] = beats[beats.size()-1] + 1;
    end
    for (int i = 0; i < NREQ; i++) acc[i] = req_valid[i] && req_ready[i];

    if (!rst_n) begin
      modelReset();
    end else if (m_owner < 0) begin
      best  = -1;
      bestd = NREQ;
      for (int i = 0; i < NREQ; i++) begin
        d = (i - m_last - 1 + 2*NREQ) % NREQ;
        if (req_valid[i] && d < bestd) begin
          best  = i;
          bestd = d;
        end
      end
      if (best >= 0) begin
        m_owner = best;
        m_gid   = best;
        m_last  = best;
        m_cnt   = 0;
      end
    end else if (exp_wen) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MAXBURST) m_owner = -1;
    end
  endtask

  task automatic finishCycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        seq[i]++;
        pos[i]++;
        if (rem[i] > 0) rem[i]--;
        if (pos[i] >= blen[i]) begin
          pos[i] = 0;
          if (rand_len) blen[i] = $urandom_range(1, 5);
        end
      end
    end
    applyStimulus();
  endtask

  task automatic stepCycle(input int n);
    repeat (n) begin
      sampleCycle();
      finishCycle();
    end
  endtask

  task automatic setupScenario();
    exp_q.delete();
    got_q.delete();
    grants.delete();
    beats.delete();
    wen_cyc.delete();
    for (int i = 0; i < NREQ; i++) begin
      en[i] = 1'b0; seq[i] = 0; pos[i] = 0; blen[i] = 1; rem[i] = -1;
    end
    rand_len   = 1'b0;
    vprob      = 100;
    fullprob   = 0;
    force_full = 1'b0;
  endtask

  task automatic doReset();
    setupScenario();
    rst_n = 1'b0;
    applyStimulus();
    stepCycle(2);
    rst_n = 1'b1;
    applyStimulus();
  endtask

  task automatic checkScoreboard(input string tag);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      checkOutput(tag, got_q[i], exp_q[i]);
  endtask

  initial begin
    int served [NREQ];
    int exp_rot [6];
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    prev_busy = 1'b0;
    modelReset();
    doReset();

    // Idle after reset: nothing requested, nothing granted.
    for (int k = 0; k < 10; k++) begin
      sampleCycle();
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_wen", fifo_wen, 0);
      checkOutput("idle_ready", req_ready, 0);
      checkOutput("idle_grant", grant_id, 0);
      finishCycle();
    end

    // Producers 0 and 2, one 3-beat burst each.
    doReset();
    en[0] = 1; en[2] = 1; blen[0] = 3; blen[2] = 3; rem[0] = 3; rem[2] = 3;
    applyStimulus();
    stepCycle(14);
    checkOutput("two_ngrants", grants.size(), 2);
    if (grants.size() == 2) begin
      checkOutput("two_grant0", grants[0], 0);
      checkOutput("two_grant1", grants[1], 2);
    end
    checkOutput("two_nbeats", got_q.size(), 6);
    if (got_q.size() == 6) begin
      for (int k = 0; k < 6; k++) checkOutput("two_data", got_q[k], mkData(k < 3 ? 0 : 2, k % 3));
      checkOutput("two_back2back", wen_cyc[1] - wen_cyc[0], 1);
      checkOutput("two_gap", wen_cyc[3] - wen_cyc[2], 2);
    end
    checkScoreboard("two_sb");

    // All producers, single-beat bursts: grants rotate.
    doReset();
    for (int i = 0; i < NREQ; i++) en[i] = 1;
    applyStimulus();
    stepCycle(20);
    checkOutput("rot_enough", grants.size() >= 8, 1);
    if (grants.size() >= 8)
      for (int k = 0; k < 8; k++) checkOutput("rot_order", grants[k], k % NREQ);
    checkScoreboard("rot_sb");

    // Producer 1 never ends its burst: forced release at MAXBURST.
    doReset();
    for (int i = 0; i < NREQ; i++) begin en[i] = 1; blen[i] = 2; end
    blen[1] = 1000;
    applyStimulus();
    stepCycle(60);
    exp_rot = '{0, 1, 2, 3, 0, 1};
    checkOutput("max_enough", grants.size() >= 6, 1);
    if (grants.size() >= 6) begin
      for (int k = 0; k < 6; k++) checkOutput("max_order", grants[k], exp_rot[k]);
      checkOutput("max_beats", beats[1], MAXBURST);
    end
    checkScoreboard("max_sb");

    // FIFO full for 5 cycles mid-burst.
    doReset();
    en[3] = 1; blen[3] = 1000;
    applyStimulus();
    stepCycle(4);
    force_full = 1;
    applyStimulus();
    for (int k = 0; k < 5; k++) begin
      sampleCycle();
      checkOutput("full_wen", fifo_wen, 0);
      checkOutput("full_ready", req_ready, 0);
      finishCycle();
    end
    force_full = 0;
    applyStimulus();
    stepCycle(25);
    checkOutput("full_nbeats", got_q.size() >= MAXBURST, 1);
    if (got_q.size() >= MAXBURST && beats.size() > 0) begin
      checkOutput("full_burst_len", beats[0], MAXBURST);
      for (int k = 0; k < MAXBURST; k++) checkOutput("full_data", got_q[k], mkData(3, k));
    end
    checkScoreboard("full_sb");

    // Reset during beat 2 of a burst from producer 1.
    doReset();
    en[1] = 1; blen[1] = 4;
    applyStimulus();
    stepCycle(2);
    rst_n = 1'b0;
    applyStimulus();
    sampleCycle();
    checkOutput("rst_wen", fifo_wen, 0);
    checkOutput("rst_ready", req_ready, 0);
    finishCycle();
    rst_n = 1'b1;
    en[1] = 0; en[0] = 1; en[2] = 1;
    applyStimulus();
    sampleCycle();
    checkOutput("rst_busy_dropped", busy, 0);
    finishCycle();
    sampleCycle();
    checkOutput("rst_regrant_busy", busy, 1);
    checkOutput("rst_regrant_id", grant_id, 0);
    finishCycle();
    stepCycle(6);
    checkScoreboard("rst_sb");

    // Random traffic with random back-pressure.
    doReset();
    rand_len = 1;
    vprob    = 70;
    fullprob = 25;
    for (int i = 0; i < NREQ; i++) begin en[i] = 1; blen[i] = $urandom_range(1, 5); end
    applyStimulus();
    stepCycle(400);
    checkScoreboard("rand_sb");
    for (int i = 0; i < NREQ; i++) served[i] = 0;
    foreach (grants[k]) served[grants[k]]++;
    for (int i = 0; i < NREQ; i++) checkOutput("rand_served", served[i] > 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
